// File: rtl/ctrl_pkt_gen.sv
// ctrl_pkt_gen: queues table-write commands and emits them as 2-beat control packets
// (header, payload) with a fixed idle gap after each packet.
module ctrl_pkt_gen #(
   parameter int         C_S_AXIS_DATA_WIDTH  = 512,
   parameter int         C_S_AXIS_TUSER_WIDTH = 128,
   parameter logic [7:0] MAGIC                = 8'hf1,
   parameter int         FIFO_DEPTH_BITS      = 2,
   parameter int         GAP_CYCLES           = 2
) (
   input  logic                               axis_clk,
   input  logic                               aresetn,
   input  logic                               cmd_valid,
   output logic                               cmd_ready,
   input  logic [4:0]                         cmd_stage_id,
   input  logic [2:0]                         cmd_resource_id,
   input  logic [7:0]                         cmd_index,
   input  logic [C_S_AXIS_DATA_WIDTH-1:0]     cmd_data,
   output logic [C_S_AXIS_DATA_WIDTH-1:0]     c_m_axis_tdata,
   output logic [C_S_AXIS_TUSER_WIDTH-1:0]    c_m_axis_tuser,
   output logic [C_S_AXIS_DATA_WIDTH/8-1:0]   c_m_axis_tkeep,
   output logic                               c_m_axis_tvalid,
   output logic                               c_m_axis_tlast,
   output logic [31:0]                        pkt_count,
   output logic                               busy
);
   localparam int DEPTH = 1 << FIFO_DEPTH_BITS;
   localparam int EW = 16 + C_S_AXIS_DATA_WIDTH;
   typedef enum logic [1:0] {IDLE, HDR, PLD, GAP} state_t;
   state_t state, state_d;
   logic [EW-1:0] mem [DEPTH];
   logic [EW-1:0] head;
   logic [FIFO_DEPTH_BITS-1:0] wr_ptr, rd_ptr;
   logic [FIFO_DEPTH_BITS:0] occ;
   logic [7:0] seq, seq_d;
   logic [31:0] cnt_d;
   logic [3:0] gap_cnt, gap_d;
   logic full, empty, push, pop;
   logic [C_S_AXIS_DATA_WIDTH-1:0] tdata_d;
   logic [C_S_AXIS_TUSER_WIDTH-1:0] tuser_d;
   logic [C_S_AXIS_DATA_WIDTH/8-1:0] tkeep_d;
   logic tvalid_d, tlast_d;
   assign full = occ == (FIFO_DEPTH_BITS+1)'(DEPTH);
   assign empty = occ == '0;
   assign cmd_ready = aresetn & ~full;
   assign push = cmd_valid & cmd_ready;
   assign pop = state == HDR;
   assign head = mem[rd_ptr];
   assign busy = state != IDLE || !empty;
   // Entry layout {stage, resource, index, data}: top byte maps straight into header byte 1.
   always_comb begin
      state_d = state;
      gap_d = gap_cnt;
      seq_d = seq;
      cnt_d = pkt_count;
      tvalid_d = 1'b0;
      tlast_d = 1'b0;
      tkeep_d = '0;
      tdata_d = '0;
      tuser_d = '0;
      if (state == HDR) begin
         state_d = PLD;
         tvalid_d = 1'b1;
         tlast_d = 1'b1;
         tkeep_d = '1;
         tdata_d = head[C_S_AXIS_DATA_WIDTH-1:0];
         seq_d = seq + 8'd1;
         cnt_d = pkt_count + 32'd1;
      end else if (state == PLD && GAP_CYCLES != 0) begin
         state_d = GAP;
         gap_d = 4'(GAP_CYCLES);
      end else if (state == GAP && gap_cnt != 4'd1) begin
         gap_d = gap_cnt - 4'd1;
      end else if (!empty) begin
         state_d = HDR;
         tvalid_d = 1'b1;
         tkeep_d = '1;
         tdata_d[31:0] = {seq, head[EW-9 -: 8], head[EW-1 -: 8], MAGIC};
         tuser_d[15:0] = 16'd128;
      end else begin
         state_d = IDLE;
      end
   end
   always_ff @(posedge axis_clk) begin
      if (push) mem[wr_ptr] <= {cmd_stage_id, cmd_resource_id, cmd_index, cmd_data};
   end
   always_ff @(posedge axis_clk) begin
      if (!aresetn) begin
         state <= IDLE;
         gap_cnt <= '0;
         seq <= '0;
         pkt_count <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ <= '0;
         c_m_axis_tdata <= '0;
         c_m_axis_tuser <= '0;
         c_m_axis_tkeep <= '0;
         c_m_axis_tvalid <= 1'b0;
         c_m_axis_tlast <= 1'b0;
      end else begin
         state <= state_d;
         gap_cnt <= gap_d;
         seq <= seq_d;
         pkt_count <= cnt_d;
         wr_ptr <= wr_ptr + FIFO_DEPTH_BITS'(push);
         rd_ptr <= rd_ptr + FIFO_DEPTH_BITS'(pop);
         occ <= occ + (FIFO_DEPTH_BITS+1)'(push) - (FIFO_DEPTH_BITS+1)'(pop);
         c_m_axis_tdata <= tdata_d;
         c_m_axis_tuser <= tuser_d;
         c_m_axis_tkeep <= tkeep_d;
         c_m_axis_tvalid <= tvalid_d;
         c_m_axis_tlast <= tlast_d;
      end
   end
endmodule
